// File: rtl/matmul_sequencer_if.sv
// Operand/result bus for the sequential matrix multiplier.
// Carries the start/busy/done handshake and the flattened matrices.
interface matmul_sequencer_if #(
   parameter int A_param = 3,
   parameter int B_param = 3,
   parameter int C_param = 8
);
   logic                           start;
   logic [A_param*B_param*8-1:0]   A1d;
   logic [B_param*C_param*8-1:0]   B1d;
   logic                           busy;
   logic                           done;
   logic [A_param*C_param*8-1:0]   Result;

   modport master (
      output start, A1d, B1d,
      input  busy, done, Result
   );

   modport slave (
      input  start, A1d, B1d,
      output busy, done, Result
   );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequential A x B multiplier using one shared 8x8 MAC.
// One MAC per cycle, mod-256 arithmetic, start/busy/done handshake.
module matmul_sequencer #(
   parameter int A_param = 3,
   parameter int B_param = 3,
   parameter int C_param = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   matmul_sequencer_if.slave bus
);
   localparam int IW = (A_param > 1) ? $clog2(A_param) : 1;
   localparam int JW = (C_param > 1) ? $clog2(C_param) : 1;
   localparam int KW = (B_param > 1) ? $clog2(B_param) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(A_param - 1);
   localparam logic [JW-1:0] J_LAST = JW'(C_param - 1);
   localparam logic [KW-1:0] K_LAST = KW'(B_param - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t r_state;
   state_t w_next;

   logic [A_param*B_param*8-1:0] r_a;
   logic [B_param*C_param*8-1:0] r_b;
   logic [7:0]                   r_res [A_param][C_param];
   logic [7:0]                   r_acc;
   logic [IW-1:0]                r_i;
   logic [JW-1:0]                r_j;
   logic [KW-1:0]                r_k;
   logic                         r_done;

   logic [7:0] w_a [A_param][B_param];
   logic [7:0] w_b [B_param][C_param];
   logic [A_param*C_param*8-1:0] w_res_flat;
   logic [7:0] w_ael;
   logic [7:0] w_bel;
   logic [7:0] w_sum;
   logic       w_k_last;
   logic       w_j_last;
   logic       w_i_last;
   logic       w_last;

   for (genvar gi = 0; gi < A_param; gi++) begin : g_ua_i
      for (genvar gk = 0; gk < B_param; gk++) begin : g_ua_k
         assign w_a[gi][gk] =
            r_a[((A_param-1-gi)*B_param + (B_param-1-gk))*8 +: 8];
      end
   end

   for (genvar gk = 0; gk < B_param; gk++) begin : g_ub_k
      for (genvar gj = 0; gj < C_param; gj++) begin : g_ub_j
         assign w_b[gk][gj] =
            r_b[((B_param-1-gk)*C_param + (C_param-1-gj))*8 +: 8];
      end
   end

   for (genvar gi = 0; gi < A_param; gi++) begin : g_pr_i
      for (genvar gj = 0; gj < C_param; gj++) begin : g_pr_j
         assign w_res_flat[((A_param-1-gi)*C_param + (C_param-1-gj))*8 +: 8] =
            r_res[gi][gj];
      end
   end

   assign w_ael    = w_a[r_i][r_k];
   assign w_bel    = w_b[r_k][r_j];
   // 8-bit product and sum: truncation gives the mod-256 result directly
   assign w_sum    = r_acc + w_ael * w_bel;
   assign w_k_last = (r_k == K_LAST);
   assign w_j_last = (r_j == J_LAST);
   assign w_i_last = (r_i == I_LAST);
   assign w_last   = w_k_last & w_j_last & w_i_last;

   assign bus.busy   = (r_state == RUN);
   assign bus.done   = r_done;
   assign bus.Result = w_res_flat;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state: accept start only in IDLE, leave RUN on last MAC
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (bus.start) w_next = RUN;
         RUN:  if (w_last)    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture, MAC accumulation, index walk and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_i    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_done <= 1'b0;
         for (int i = 0; i < A_param; i++)
            for (int j = 0; j < C_param; j++)
               r_res[i][j] <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a   <= bus.A1d;
                  r_b   <= bus.B1d;
                  r_acc <= '0;
                  r_i   <= '0;
                  r_j   <= '0;
                  r_k   <= '0;
                  for (int i = 0; i < A_param; i++)
                     for (int j = 0; j < C_param; j++)
                        r_res[i][j] <= '0;
               end
            end
            RUN: begin
               if (!w_k_last) begin
                  r_acc <= w_sum;
                  r_k   <= r_k + 1'b1;
               end else begin
                  r_res[r_i][r_j] <= w_sum;
                  r_acc <= '0;
                  r_k   <= '0;
                  if (w_j_last) begin
                     r_j <= '0;
                     r_i <= w_i_last ? '0 : r_i + 1'b1;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end
               if (w_last) r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: vector table, random model check,
// and hand sequences for busy protection, back-to-back and reset.
module tb_matmul_sequencer;
   localparam int AP = 3;
   localparam int BP = 3;
   localparam int CP = 8;
   localparam int AW = AP*BP*8;
   localparam int BW = BP*CP*8;
   localparam int RW = AP*CP*8;
   localparam int N  = AP*BP*CP;

   typedef struct {
      string         name;
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [RW-1:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   vec_t tbl[$];

   matmul_sequencer_if #(.A_param(AP), .B_param(BP), .C_param(CP)) bus();

   matmul_sequencer #(.A_param(AP), .B_param(BP), .C_param(CP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [AW-1:0] GA = {
      8'd1, 8'd0, 8'd2,
      8'd3, 8'd2, 8'd1,
      8'd2, 8'd3, 8'd2};
   localparam logic [BW-1:0] GB = {
      8'd0, 8'd1, 8'd4, 8'd3, 8'd5, 8'd3, 8'd2, 8'd1,
      8'd4, 8'd3, 8'd9, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2,
      8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0};
   localparam logic [RW-1:0] GR = {
      8'd2,  8'd5,  8'd10, 8'd9,  8'd11, 8'd3, 8'd2,  8'd1,
      8'd9,  8'd11, 8'd33, 8'd12, 8'd18, 8'd11, 8'd10, 8'd7,
      8'd14, 8'd15, 8'd41, 8'd12, 8'd16, 8'd9, 8'd10, 8'd8};
   localparam logic [AW-1:0] IA = {
      8'd1, 8'd0, 8'd0,
      8'd0, 8'd1, 8'd0,
      8'd0, 8'd0, 8'd1};

   function automatic logic [RW-1:0] model(logic [AW-1:0] a,
                                           logic [BW-1:0] b);
      logic [RW-1:0] r;
      int unsigned   s;
      int unsigned   ea;
      int unsigned   eb;
      r = '0;
      for (int i = 0; i < AP; i++) begin
         for (int j = 0; j < CP; j++) begin
            s = 0;
            for (int k = 0; k < BP; k++) begin
               ea = 32'(a[((AP-1-i)*BP + (BP-1-k))*8 +: 8]);
               eb = 32'(b[((BP-1-k)*CP + (CP-1-j))*8 +: 8]);
               s  = s + ea * eb;
            end
            r[((AP-1-i)*CP + (CP-1-j))*8 +: 8] = 8'(s % 256);
         end
      end
      return r;
   endfunction

   task automatic check(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done === 1'b1) break;
      end
   endtask

   task automatic pulse_start(logic [AW-1:0] a, logic [BW-1:0] b);
      bus.A1d   = a;
      bus.B1d   = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic run_check(string name, logic [AW-1:0] a,
                            logic [BW-1:0] b, logic [RW-1:0] exp);
      int lat;
      pulse_start(a, b);
      check({name, ".busy_rise"}, RW'(bus.busy), RW'(1));
      wait_done(lat);
      check({name, ".latency"}, RW'(lat), RW'(N));
      check({name, ".result"}, bus.Result, exp);
      check({name, ".busy_fall"}, RW'(bus.busy), RW'(0));
      @(posedge clk);
      #1;
      check({name, ".done_pulse"}, RW'(bus.done), RW'(0));
   endtask

   initial begin
      int lat;
      vec_t v;
      logic [AW-1:0] ra;
      logic [BW-1:0] rb;
      n_cmp = 0;
      n_bad = 0;

      // reset held with start high
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.A1d   = GA;
      bus.B1d   = GB;
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy",   RW'(bus.busy), RW'(0));
      check("rst.done",   RW'(bus.done), RW'(0));
      check("rst.result", bus.Result, '0);
      bus.start = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      check("idle.busy", RW'(bus.busy), RW'(0));

      tbl.push_back('{"golden", GA, GB, GR});
      tbl.push_back('{"overflow", '1, '1, {(AP*CP){8'd3}}});
      tbl.push_back('{"identity", IA, GB, GB[BW-1 -: RW]});
      for (int n = 0; n < 4; n++) begin
         ra = AW'({$urandom, $urandom, $urandom});
         rb = BW'({$urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom});
         tbl.push_back('{$sformatf("rand%0d", n), ra, rb, model(ra, rb)});
      end
      foreach (tbl[n]) begin
         v = tbl[n];
         run_check(v.name, v.a, v.b, v.exp);
      end

      // inputs change and start pulses mid-run
      pulse_start(GA, GB);
      repeat (19) @(posedge clk);
      #1;
      bus.A1d   = '1;
      bus.B1d   = '1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat);
      check("prot.latency", RW'(lat + 20), RW'(N));
      check("prot.result", bus.Result, GR);
      repeat (3) @(posedge clk);
      #1;
      check("prot.no_rerun", RW'(bus.busy), RW'(0));

      // back-to-back: start accepted in the done cycle
      pulse_start(GA, GB);
      wait_done(lat);
      check("b2b.first", bus.Result, GR);
      pulse_start(IA, GB);
      check("b2b.busy", RW'(bus.busy), RW'(1));
      check("b2b.done_low", RW'(bus.done), RW'(0));
      wait_done(lat);
      check("b2b.latency", RW'(lat), RW'(N));
      check("b2b.result", bus.Result, GB[BW-1 -: RW]);

      // asynchronous reset mid-run
      @(posedge clk);
      #1;
      pulse_start(GA, GB);
      repeat (29) @(posedge clk);
      #1;
      check("mrst.partial_nz", RW'(bus.Result != '0), RW'(1));
      #3;
      rst_n = 1'b0;
      #1;
      check("mrst.busy",   RW'(bus.busy), RW'(0));
      check("mrst.result", bus.Result, '0);
      lat = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) rst_n = 1'b1;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) lat++;
      end
      check("mrst.quiet", RW'(lat), RW'(0));
      run_check("mrst.rerun", GA, GB, GR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
